reg_resp_tx: RTL and testbench

//  Downstream of the UART register-read command decoder: takes one read word
//  (r_data/r_valid) and serialises it as a byte-wide response frame

---
 rtl/reg_resp_tx_if.sv | 21 ++
 rtl/reg_resp_tx.sv | 152 +++++++++++++++
 tb/tb_reg_resp_tx.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_resp_tx_if.sv
// Valid/ready byte or word stream between the read decoder, this block and the UART.
// The master drives data/valid and the slave drives ready.
interface reg_resp_tx_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/reg_resp_tx.sv
// Serialises one register-read word into a HEADER | payload | TERMINATOR byte frame.
// The payload is either raw bytes or uppercase ASCII hex, most significant first.
module reg_resp_tx #(
    parameter int                    DIN_WORD   = 32,
    parameter int                    UART_WORD  = 8,
    parameter int                    HEADER_LEN = 3,
    parameter logic [8*HEADER_LEN-1:0] HEADER   = 24'h247261,
    parameter logic [7:0]            TERMINATOR = 8'h0A,
    parameter bit                    HEX_ASCII  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_resp_tx_if.slave         rd,
    reg_resp_tx_if.master        tx,
    output logic                 drop,
    output logic [7:0]           drop_cnt
);

    localparam int NP    = HEX_ASCII ? DIN_WORD / 4 : DIN_WORD / 8;
    localparam int MAXN  = (HEADER_LEN > NP) ? HEADER_LEN : NP;
    localparam int IDX_W = $clog2(MAXN + 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        TERM
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIN_WORD-1:0]    shadow_q, shadow_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [UART_WORD-1:0]   tx_data_q, tx_data_d;
    logic                   drop_q, drop_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;

    logic r_ready;
    logic accept;
    logic hs;

    function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] i);
        int k;
        k = HEADER_LEN - 1 - int'(i);
        return HEADER[8*k +: 8];
    endfunction

    // 8'h37 is 'A' minus 10, so nibbles A-F land on 'A'..'F'
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] pay_byte(
        input logic [IDX_W-1:0]    i,
        input logic [DIN_WORD-1:0] w
    );
        int k;
        k = NP - 1 - int'(i);
        if (HEX_ASCII) begin
            return hex_char(w[4*k +: 4]);
        end
        return w[8*k +: 8];
    endfunction

    assign r_ready  = (state_q == IDLE) | ((state_q == TERM) & tx.ready);
    assign accept   = rd.valid & r_ready;
    assign hs       = tx_valid_q & tx.ready;

    assign rd.ready = r_ready;
    assign tx.valid = tx_valid_q;
    assign tx.data  = tx_data_q;
    assign drop     = drop_q;
    assign drop_cnt = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shadow_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = accept ? rd.data : shadow_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HDR;
                    idx_d   = '0;
                end
            end
            HDR: begin
                if (hs) begin
                    if (idx_q == IDX_W'(HEADER_LEN - 1)) begin
                        state_d = PAY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PAY: begin
                if (hs) begin
                    if (idx_q == IDX_W'(NP - 1)) begin
                        state_d = TERM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            TERM: begin
                // a word taken on the terminator handshake chains straight into its header
                if (hs) begin
                    state_d = accept ? HDR : IDLE;
                    idx_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        tx_valid_d = (state_d != IDLE);
        tx_data_d  = '0;
        unique case (state_d)
            IDLE: tx_data_d = '0;
            HDR:  tx_data_d = UART_WORD'(hdr_byte(idx_d));
            PAY:  tx_data_d = UART_WORD'(pay_byte(idx_d, shadow_d));
            TERM: tx_data_d = UART_WORD'(TERMINATOR);
        endcase
        drop_d     = rd.valid & ~r_ready;
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_reg_resp_tx.sv
// Bench for reg_resp_tx: raw and hex instances against a frame-level reference model.
// Frames are predicted from the word with plain arithmetic and checked cycle by cycle or by scoreboard.
module tb_reg_resp_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       drop_raw, drop_hex;
    logic [7:0] cnt_raw, cnt_hex;

    int n_checks = 0;
    int n_fail   = 0;

    reg_resp_tx_if #(.W(32)) rd_raw ();
    reg_resp_tx_if #(.W(8))  tx_raw ();
    reg_resp_tx_if #(.W(32)) rd_hex ();
    reg_resp_tx_if #(.W(8))  tx_hex ();

    always #5 clk = ~clk;

    reg_resp_tx #(.HEX_ASCII(1'b0)) u_raw (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd_raw),
        .tx       (tx_raw),
        .drop     (drop_raw),
        .drop_cnt (cnt_raw)
    );

    reg_resp_tx #(.HEX_ASCII(1'b1)) u_hex (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd_hex),
        .tx       (tx_hex),
        .drop     (drop_hex),
        .drop_cnt (cnt_hex)
    );

    function automatic logic [7:0] model_byte(input logic [31:0] w, input bit hex, input int k);
        string           hdr;
        string           hx;
        int              np;
        int              j;
        longint unsigned v;
        longint unsigned p;
        hdr = "$ra";
        hx  = "0123456789ABCDEF";
        np  = hex ? 8 : 4;
        if (k < 3) return hdr[k];
        if (k >= 3 + np) return 8'h0A;
        j = k - 3;
        v = w;
        p = 1;
        for (int i = 0; i < np - 1 - j; i++) p = p * (hex ? 16 : 256);
        v = v / p;
        if (hex) return hx[int'(v % 16)];
        return 8'(v % 256);
    endfunction

    // scoreboard for the raw instance
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         stall_err  = 0;
    int         drop_model = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            drop_model <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && !(tx_raw.valid && tx_raw.data == prev_data))
                stall_err <= stall_err + 1;
            prev_stall <= tx_raw.valid && !tx_raw.ready;
            prev_data  <= tx_raw.data;
            if (tx_raw.valid && tx_raw.ready) got_q.push_back(tx_raw.data);
            if (rd_raw.valid && rd_raw.ready)
                for (int k = 0; k < 8; k++) exp_q.push_back(model_byte(rd_raw.data, 1'b0, k));
            if (rd_raw.valid && !rd_raw.ready) drop_model <= drop_model + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_raw_frame(input logic [31:0] w);
        tx_raw.ready = 1'b1;
        rd_raw.data  = w;
        rd_raw.valid = 1'b1;
        tick;
        rd_raw.valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (tx_raw.valid !== 1'b1 || tx_raw.data !== model_byte(w, 1'b0, k)) begin
                n_fail++;
                $display("FAIL raw_byte w=%h k=%0d got v=%b d=%h exp %h", w, k,
                         tx_raw.valid, tx_raw.data, model_byte(w, 1'b0, k));
            end
            tick;
        end
        @(negedge clk);
        n_checks++;
        if (tx_raw.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_end_valid w=%h got %b exp 0", w, tx_raw.valid);
        end
        tick;
    endtask

    task automatic run_hex_frame(input logic [31:0] w);
        tx_hex.ready = 1'b1;
        rd_hex.data  = w;
        rd_hex.valid = 1'b1;
        tick;
        rd_hex.valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (tx_hex.valid !== 1'b1 || tx_hex.data !== model_byte(w, 1'b1, k)) begin
                n_fail++;
                $display("FAIL hex_byte w=%h k=%0d got v=%b d=%h exp %h", w, k,
                         tx_hex.valid, tx_hex.data, model_byte(w, 1'b1, k));
            end
            tick;
        end
        @(negedge clk);
        n_checks++;
        if (tx_hex.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hex_end_valid w=%h got %b exp 0", w, tx_hex.valid);
        end
        tick;
    endtask

    task automatic drain_and_compare(input int gb, input int eb, input string name);
        int c;
        tx_raw.ready = 1'b1;
        c = 0;
        while ((got_q.size() - gb) < (exp_q.size() - eb) && c < 400) begin
            tick;
            c++;
        end
        repeat (3) tick;
        n_checks++;
        if ((got_q.size() - gb) != (exp_q.size() - eb)) begin
            n_fail++;
            $display("FAIL %s_len got %0d exp %0d", name, got_q.size() - gb, exp_q.size() - eb);
        end
        for (int i = 0; i < exp_q.size() - eb && gb + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[gb+i] !== exp_q[eb+i]) begin
                n_fail++;
                $display("FAIL %s_byte %0d got %h exp %h", name, i, got_q[gb+i], exp_q[eb+i]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rd_raw.valid = 1'b0;
        rd_raw.data  = '0;
        rd_hex.valid = 1'b0;
        rd_hex.data  = '0;
        tx_raw.ready = 1'b0;
        tx_hex.ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx_raw.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", tx_raw.valid); end
        n_checks++;
        if (tx_raw.data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h exp 00", tx_raw.data); end
        n_checks++;
        if (drop_raw !== 1'b0) begin n_fail++; $display("FAIL rst_drop got %b exp 0", drop_raw); end
        n_checks++;
        if (cnt_raw !== 8'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", cnt_raw); end
        n_checks++;
        if (rd_raw.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", rd_raw.ready); end
        n_checks++;
        if (tx_hex.valid !== 1'b0 || rd_hex.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hex got v=%b r=%b exp 0/1", tx_hex.valid, rd_hex.ready);
        end
        tick;
    endtask

    task automatic test_raw_frame;
        run_raw_frame(32'hDEADBEEF);
        for (int i = 0; i < 3; i++) run_raw_frame($urandom);
    endtask

    task automatic test_hex_frame;
        run_hex_frame(32'h00A1F93C);
        run_hex_frame(32'hFEDCBA98);
        for (int i = 0; i < 2; i++) run_hex_frame($urandom);
    endtask

    task automatic test_random_ready;
        int gb, eb, s0, sent, cyc;
        gb   = got_q.size();
        eb   = exp_q.size();
        s0   = stall_err;
        sent = 0;
        cyc  = 0;
        while (sent < 6 && cyc < 2000) begin
            tx_raw.ready = 1'($urandom_range(0, 1));
            #1;
            if (rd_raw.ready && $urandom_range(0, 1) == 1) begin
                rd_raw.data  = $urandom;
                rd_raw.valid = 1'b1;
                sent++;
            end
            tick;
            rd_raw.valid = 1'b0;
            cyc++;
        end
        n_checks++;
        if (sent != 6) begin n_fail++; $display("FAIL rr_sent got %0d exp 6", sent); end
        drain_and_compare(gb, eb, "rr");
        n_checks++;
        if (stall_err != s0) begin
            n_fail++;
            $display("FAIL rr_stable got %0d changes exp 0", stall_err - s0);
        end
        n_checks++;
        if (cnt_raw !== 8'd0) begin n_fail++; $display("FAIL rr_nodrop got %0d exp 0", cnt_raw); end
    endtask

    task automatic test_drop;
        int gb, eb, want;
        gb = got_q.size();
        eb = exp_q.size();
        tx_raw.ready = 1'b1;
        rd_raw.data  = $urandom;
        rd_raw.valid = 1'b1;
        tick;
        rd_raw.valid = 1'b0;
        repeat (4) tick;
        rd_raw.data  = $urandom;
        rd_raw.valid = 1'b1;
        tick;
        rd_raw.valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (drop_raw !== 1'b1) begin n_fail++; $display("FAIL drop_pulse got %b exp 1", drop_raw); end
        n_checks++;
        if (cnt_raw !== 8'd1) begin n_fail++; $display("FAIL drop_cnt1 got %0d exp 1", cnt_raw); end
        tick;
        @(negedge clk);
        n_checks++;
        if (drop_raw !== 1'b0) begin n_fail++; $display("FAIL drop_single got %b exp 0", drop_raw); end
        drain_and_compare(gb, eb, "drop1");

        gb = got_q.size();
        eb = exp_q.size();
        tick;
        rd_raw.data  = $urandom;
        rd_raw.valid = 1'b1;
        tx_raw.ready = 1'b0;
        tick;
        repeat (300) begin
            rd_raw.data = $urandom;
            tick;
        end
        rd_raw.valid = 1'b0;
        @(negedge clk);
        want = (drop_model > 255) ? 255 : drop_model;
        n_checks++;
        if (cnt_raw !== 8'(want) || want != 255) begin
            n_fail++;
            $display("FAIL drop_sat got %0d exp %0d (model %0d)", cnt_raw, want, drop_model);
        end
        drain_and_compare(gb, eb, "drop300");
    endtask

    task automatic test_back_to_back;
        logic [31:0] w1, w2;
        logic [7:0]  e;
        w1 = $urandom;
        w2 = $urandom;
        tx_raw.ready = 1'b1;
        rd_raw.data  = w1;
        rd_raw.valid = 1'b1;
        tick;
        rd_raw.valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                rd_raw.data  = w2;
                rd_raw.valid = 1'b1;
            end
            e = (i < 8) ? model_byte(w1, 1'b0, i) : model_byte(w2, 1'b0, i - 8);
            @(negedge clk);
            if (i == 7) begin
                n_checks++;
                if (rd_raw.ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready got %b exp 1", rd_raw.ready);
                end
            end
            n_checks++;
            if (tx_raw.valid !== 1'b1 || tx_raw.data !== e) begin
                n_fail++;
                $display("FAIL b2b_byte %0d got v=%b d=%h exp %h", i, tx_raw.valid, tx_raw.data, e);
            end
            tick;
            rd_raw.valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (tx_raw.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b exp 0", tx_raw.valid); end
        tick;
    endtask

    task automatic test_reset_mid;
        tx_raw.ready = 1'b1;
        rd_raw.data  = $urandom;
        rd_raw.valid = 1'b1;
        tick;
        rd_raw.valid = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx_raw.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", tx_raw.valid); end
        n_checks++;
        if (cnt_raw !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt got %0d exp 0", cnt_raw); end
        n_checks++;
        if (rd_raw.ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", rd_raw.ready); end
        tick;
        run_raw_frame(32'h12345678);
        run_raw_frame($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raw_frame();
        test_hex_frame();
        test_random_ready();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
